traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_phase_scheduler.sv | 151 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler
// Purpose  : Two-road intersection phase scheduler with demand latches,
//            min/max green timing, rest-in-green and an optional pedestrian
//            walk phase served from all-red.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                  in   system clock, rising edge
//   rst                  in   asynchronous active-high reset
//   req_a, req_b         in   vehicle sensors (level)
//   ped_req              in   pedestrian push-button (pulse)
//   reda/yela/grna       out  road A lamps (registered, one-hot)
//   redb/yelb/grnb       out  road B lamps (registered, one-hot)
//   walk                 out  pedestrian walk lamp (registered)
//   phase[2:0]           out  current state code
// Configuration
//   PED_PHASE_EN         when defined, the pedestrian walk phase is built in;
//                        otherwise ped_req is ignored and WALK is unreachable.
// ============================================================================
module traffic_phase_scheduler #(
  parameter int GRN_MIN  = 4,
  parameter int GRN_MAX  = 12,
  parameter int YEL_T    = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ped_req,
  output logic       reda,
  output logic       yela,
  output logic       grna,
  output logic       redb,
  output logic       yelb,
  output logic       grnb,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_A_GRN = 3'd1,
    S_A_YEL = 3'd2,
    S_AR_AB = 3'd3,
    S_B_GRN = 3'd4,
    S_B_YEL = 3'd5,
    S_AR_BA = 3'd6,
    S_WALK  = 3'd7
  } state_t;

  // Timer thresholds: a state lasting N cycles exits when timer == N-1.
  localparam logic [4:0] c_grn_min_m1 = 5'(GRN_MIN - 1);
  localparam logic [4:0] c_grn_max_m1 = 5'(GRN_MAX - 1);
  localparam logic [4:0] c_yel_m1     = 5'(YEL_T - 1);
  localparam logic [4:0] c_allred_m1  = 5'(ALLRED_T - 1);
  localparam logic [4:0] c_walk_m1    = 5'(WALK_T - 1);

  // Lamp vector order: {reda, yela, grna, redb, yelb, grnb, walk}
  localparam logic [6:0] c_lamps_rst = 7'b100_100_0;

  state_t     state_q, state_d;
  logic [4:0] timer_q, timer_d;
  logic       pend_a_q, pend_a_d;
  logic       pend_b_q, pend_b_d;
  logic       pend_p_q, pend_p_d;
  logic       served_b_q, served_b_d;  // last green served was road B
  logic [6:0] lamps_q, lamps_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (timer_q == c_allred_m1) state_d = pend_p_q ? S_WALK : S_A_GRN;
      S_A_GRN: if ((timer_q >= c_grn_min_m1) && (pend_b_q || pend_p_q) &&
                   (!req_a || (timer_q >= c_grn_max_m1))) state_d = S_A_YEL;
      S_A_YEL: if (timer_q == c_yel_m1) state_d = S_AR_AB;
      S_AR_AB: if (timer_q == c_allred_m1) state_d = pend_p_q ? S_WALK : S_B_GRN;
      S_B_GRN: if ((timer_q >= c_grn_min_m1) && (pend_a_q || pend_p_q) &&
                   (!req_b || (timer_q >= c_grn_max_m1))) state_d = S_B_YEL;
      S_B_YEL: if (timer_q == c_yel_m1) state_d = S_AR_BA;
      S_AR_BA: if (timer_q == c_allred_m1) state_d = pend_p_q ? S_WALK : S_A_GRN;
      S_WALK:  if (timer_q == c_walk_m1) state_d = served_b_q ? S_A_GRN : S_B_GRN;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    // Timer restarts on every state entry and saturates while resting.
    if (state_d != state_q)     timer_d = 5'd0;
    else if (timer_q == 5'd31)  timer_d = timer_q;
    else                        timer_d = timer_q + 5'd1;

    // A request seen while the road is green (or on the cycle it turns
    // green) is already being served, so it never latches.
    pend_a_d = ((state_q == S_A_GRN) || (state_d == S_A_GRN)) ? 1'b0 : (pend_a_q | req_a);
    pend_b_d = ((state_q == S_B_GRN) || (state_d == S_B_GRN)) ? 1'b0 : (pend_b_q | req_b);

`ifdef PED_PHASE_EN
    pend_p_d = ((state_q == S_WALK) || (state_d == S_WALK)) ? 1'b0 : (pend_p_q | ped_req);
`else
    pend_p_d = 1'b0;
`endif

    served_b_d = served_b_q;
    if (state_d == S_B_GRN)      served_b_d = 1'b1;
    else if (state_d == S_A_GRN) served_b_d = 1'b0;

    // Lamps are decoded from the next state so they change together with it.
    case (state_d)
      S_A_GRN: lamps_d = 7'b001_100_0;
      S_A_YEL: lamps_d = 7'b010_100_0;
      S_B_GRN: lamps_d = 7'b100_001_0;
      S_B_YEL: lamps_d = 7'b100_010_0;
      S_WALK:  lamps_d = 7'b100_100_1;
      default: lamps_d = c_lamps_rst;
    endcase
  end

`ifndef PED_PHASE_EN
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      timer_q    <= 5'd0;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      pend_p_q   <= 1'b0;
      served_b_q <= 1'b1;  // so a walk straight out of INIT is followed by A
      lamps_q    <= c_lamps_rst;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      pend_p_q   <= pend_p_d;
      served_b_q <= served_b_d;
      lamps_q    <= lamps_d;
    end
  end

  assign {reda, yela, grna, redb, yelb, grnb, walk} = lamps_q;
  assign phase = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_scheduler
// Purpose  : Self-checking bench for traffic_phase_scheduler. A phase-level
//            model (unbounded cycle counts, integer phase codes) is compared
//            against the DUT every cycle; directed sequences pin the model
//            with hand-computed phase traces.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

  localparam int GRN_MIN  = 4;
  localparam int GRN_MAX  = 12;
  localparam int YEL_T    = 2;
  localparam int ALLRED_T = 1;
  localparam int WALK_T   = 6;
`ifdef PED_PHASE_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0, ped_req = 1'b0;
  logic reda, yela, grna, redb, yelb, grnb, walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  traffic_phase_scheduler #(
    .GRN_MIN(GRN_MIN), .GRN_MAX(GRN_MAX), .YEL_T(YEL_T),
    .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .ped_req(ped_req),
    .reda(reda), .yela(yela), .grna(grna), .redb(redb), .yelb(yelb),
    .grnb(grnb), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  // ---------------- phase-level model ----------------
  int m_ph, m_cnt, m_nxt;
  bit m_pa, m_pb, m_pp, m_lastb;

  // Next phase from the written rules; cnt+1 is cycles already spent.
  function automatic int f_next(int ph, int cnt, bit pa, bit pb, bit pp,
                                bit lastb, bit ra, bit rb);
    int  spent;
    bit  ped;
    spent = cnt + 1;
    ped   = PED && pp;
    case (ph)
      0: return (spent >= ALLRED_T) ? (ped ? 7 : 1) : 0;
      1: return (spent >= GRN_MIN && (pb || ped) && (!ra || spent >= GRN_MAX)) ? 2 : 1;
      2: return (spent >= YEL_T) ? 3 : 2;
      3: return (spent >= ALLRED_T) ? (ped ? 7 : 4) : 3;
      4: return (spent >= GRN_MIN && (pa || ped) && (!rb || spent >= GRN_MAX)) ? 5 : 4;
      5: return (spent >= YEL_T) ? 6 : 5;
      6: return (spent >= ALLRED_T) ? (ped ? 7 : 1) : 6;
      7: return (spent >= WALK_T) ? (lastb ? 1 : 4) : 7;
      default: return 0;
    endcase
  endfunction

  // {reda, yela, grna, redb, yelb, grnb, walk} for each phase.
  function automatic logic [6:0] f_lamps(int ph);
    case (ph)
      1: return 7'b001_100_0;
      2: return 7'b010_100_0;
      4: return 7'b100_001_0;
      5: return 7'b100_010_0;
      7: return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  always_comb m_nxt = f_next(m_ph, m_cnt, m_pa, m_pb, m_pp, m_lastb, req_a, req_b);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_cnt <= 0; m_pa <= 1'b0; m_pb <= 1'b0; m_pp <= 1'b0; m_lastb <= 1'b1;
    end else begin
      m_ph  <= m_nxt;
      m_cnt <= (m_nxt != m_ph) ? 0 : m_cnt + 1;
      m_pa  <= (m_ph == 1 || m_nxt == 1) ? 1'b0 : (m_pa | req_a);
      m_pb  <= (m_ph == 4 || m_nxt == 4) ? 1'b0 : (m_pb | req_b);
      m_pp  <= !PED ? 1'b0 : ((m_ph == 7 || m_nxt == 7) ? 1'b0 : (m_pp | ped_req));
      if (m_nxt == 1) m_lastb <= 1'b0;
      else if (m_nxt == 4) m_lastb <= 1'b1;
    end
  end

  // Per-cycle comparison, well clear of both clock edges.
  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      n_checks++;
      if (phase !== 3'(m_ph) ||
          {reda, yela, grna, redb, yelb, grnb, walk} !== f_lamps(m_ph)) begin
        n_err++;
        $display("FAIL model t=%0t: phase %0d lamps %b, required phase %0d lamps %b",
                 $time, phase, {reda, yela, grna, redb, yelb, grnb, walk},
                 m_ph, f_lamps(m_ph));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0d required %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ph(input string nm, input int ph);
    lit(nm, 32'(phase), 32'(ph));
    step(1);
  endtask

  // Reset, then release with the given requests; returns in A_GRN cycle 0.
  task automatic do_reset(input bit ra, input bit rb);
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ped_req = 1'b0;
    #1;
    lit("rst_phase", 32'(phase), 0);
    lit("rst_lamps", 32'({reda, yela, grna, redb, yelb, grnb, walk}), 32'(7'b100_100_0));
    @(negedge clk);
    req_a = ra; req_b = rb; rst = 1'b0;
    lit("init_phase", 32'(phase), 0);
    step(1);
  endtask

  initial begin
    @(negedge clk);
    chk_on = 1'b1;

    // Idle: INIT for one cycle, then A green rests.
    do_reset(1'b0, 1'b0);
    lit("idle_a_grn", 32'(phase), 1);
    lit("idle_grna", 32'(grna), 1);
    lit("idle_redb", 32'(redb), 1);
    step(25);
    lit("rest_a_grn", 32'(phase), 1);

    // req_b pulse at timer 1: 4 green, 2 yellow, 1 all-red, B green.
    do_reset(1'b0, 1'b0);
    step(1); req_b = 1'b1;
    step(1); req_b = 1'b0;
    expect_ph("mingrn_t2", 1);
    expect_ph("mingrn_t3", 1);
    expect_ph("mingrn_y0", 2);
    expect_ph("mingrn_y1", 2);
    expect_ph("mingrn_ar", 3);
    lit("mingrn_grnb", 32'(grnb), 1);
    expect_ph("mingrn_b", 4);
    step(6);
    lit("mingrn_b_rest", 32'(phase), 4);

`ifdef PED_PHASE_EN
    // Ped pulse in B green: yellow, all-red, 6 walk cycles, then A.
    ped_req = 1'b1; step(1); ped_req = 1'b0;
    expect_ph("ped_b", 4);
    expect_ph("ped_y0", 5);
    expect_ph("ped_y1", 5);
    expect_ph("ped_ar", 6);
    for (int i = 0; i < WALK_T; i++) begin
      lit("ped_walk", 32'(walk), 1);
      lit("ped_reds", 32'({reda, redb}), 3);
      expect_ph("ped_walk_ph", 7);
    end
    lit("ped_walk_off", 32'(walk), 0);
    expect_ph("ped_then_a", 1);
    step(8);
    lit("ped_a_rest", 32'(phase), 1);

    // Walk and road B both pending at all-red: walk first, then B.
    req_b = 1'b1; ped_req = 1'b1; step(1); req_b = 1'b0; ped_req = 1'b0;
    expect_ph("both_a", 1);
    expect_ph("both_y0", 2);
    expect_ph("both_y1", 2);
    expect_ph("both_ar", 3);
    for (int i = 0; i < WALK_T; i++) expect_ph("both_walk", 7);
    expect_ph("both_then_b", 4);
`else
    // Ped button ignored entirely.
    for (int i = 0; i < 10; i++) begin
      ped_req = 1'b1; step(1); ped_req = 1'b0; step(1);
      lit("noped_walk", 32'(walk), 0);
    end
    lit("noped_b_rest", 32'(phase), 4);
    req_a = 1'b1; step(1); req_a = 1'b0;
    expect_ph("noped_b", 4);
    expect_ph("noped_y0", 5);
    expect_ph("noped_y1", 5);
    expect_ph("noped_ar", 6);
    expect_ph("noped_a", 1);
    for (int i = 0; i < 6; i++) begin
      ped_req = 1'b1; step(1); ped_req = 1'b0; step(1);
    end
    lit("noped_a_rest", 32'(phase), 1);
`endif

    // req_a held, req_b pending from the start: A green capped at 12.
    do_reset(1'b1, 1'b1);
    req_b = 1'b0;
    for (int i = 0; i < GRN_MAX; i++) expect_ph("maxgrn_a", 1);
    expect_ph("maxgrn_y0", 2);
    expect_ph("maxgrn_y1", 2);
    expect_ph("maxgrn_ar", 3);
    for (int i = 0; i < GRN_MIN; i++) expect_ph("maxgrn_b", 4);
    expect_ph("maxgrn_by0", 5);
    expect_ph("maxgrn_by1", 5);
    expect_ph("maxgrn_bar", 6);
    expect_ph("maxgrn_back_a", 1);
    req_a = 1'b0;

    // Reset in the middle of A yellow.
    do_reset(1'b0, 1'b0);
    step(1); req_b = 1'b1;
    step(1); req_b = 1'b0;
    step(2);
    lit("midyel_in_yel", 32'(phase), 2);
    rst = 1'b1;
    #1;
    lit("midyel_phase", 32'(phase), 0);
    lit("midyel_reds", 32'({reda, redb}), 3);
    lit("midyel_yela", 32'(yela), 0);
    @(negedge clk);
    rst = 1'b0;
    step(12);
    lit("midyel_pend_clr", 32'(phase), 1);

    // Mixed traffic pattern, checked by the model only.
    for (int i = 0; i < 160; i++) begin
      req_a   = ((i % 11) < 4);
      req_b   = ((i % 13) < 5);
      ped_req = ((i % 29) == 3);
      step(1);
    end
    req_a = 1'b0; req_b = 1'b0; ped_req = 1'b0;
    step(3);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
